// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the 64-bit timer APB read side: bus/counter widths,
// TDR register offsets and the read-controller state encoding.
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 64;
    localparam int unsigned WAIT_W = 4;     // holds WAIT_CYCLES 0..15

    localparam logic [11:0] TDR0_OFS = 12'h004;
    localparam logic [11:0] TDR1_OFS = 12'h008;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_snap_reg.sv
// -----------------------------------------------------------------------------
// timer_snap_reg
// Holds the upper counter half captured by a TDR0 read until TDR1 consumes it.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_load          capture i_load_data and mark the snapshot valid
//   i_load_data     upper counter half to hold
//   i_consume       TDR1 read used the snapshot
//   i_invalidate    counter reloaded by a write, snapshot is stale
//   o_snap_hi       held upper half
//   o_snap_valid    snapshot is held and not yet consumed
// -----------------------------------------------------------------------------
module timer_snap_reg
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_consume,
    input  logic              i_invalidate,
    output logic [DATA_W-1:0] o_snap_hi,
    output logic              o_snap_valid
);

    logic [DATA_W-1:0] r_snap_hi;
    logic              r_snap_valid;

    // A new load always replaces an older snapshot; no stacking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_hi    <= '0;
            r_snap_valid <= 1'b0;
        end else if (i_load) begin
            r_snap_hi    <= i_load_data;
            r_snap_valid <= 1'b1;
        end else if (i_consume || i_invalidate) begin
            r_snap_valid <= 1'b0;
        end
    end

    assign o_snap_hi    = r_snap_hi;
    assign o_snap_valid = r_snap_valid;

endmodule

// File: rtl/timer_rd_ctrl.sv
// -----------------------------------------------------------------------------
// timer_rd_ctrl
// APB read side of the 64-bit timer. TDR0 returns cnt[31:0] and snapshots the
// upper half; the following TDR1 read returns that snapshot so the pair of
// reads is coherent. Completes every timer APB access (pready/pslverr).
// Ports:
//   sys_clk, sys_rst    clock, async active-high reset
//   psel/penable/pwrite/paddr   APB request
//   cnt                 live 64-bit counter value
//   prdata              read data, nonzero only on a completing read
//   pready              one-cycle transfer completion
//   pslverr             error response, only alongside pready
//   snap_valid          upper-half snapshot held, awaiting TDR1 read
// -----------------------------------------------------------------------------
module timer_rd_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 12,
    parameter logic [ADDR_W-1:0]  TDR0_ADDR   = ADDR_W'(TDR0_OFS),
    parameter logic [ADDR_W-1:0]  TDR1_ADDR   = ADDR_W'(TDR1_OFS),
    parameter int unsigned        WAIT_CYCLES = 0
)(
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [CNT_W-1:0]  cnt,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              snap_valid
);

    state_e             r_state;
    state_e             w_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0]  r_rd_q;
    logic               r_err_q;
    logic [DATA_W-1:0]  r_prdata;
    logic               r_pready;
    logic               r_pslverr;

    logic               w_capture;
    logic               w_hit0;
    logic               w_hit1;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_err;
    logic               w_load;
    logic               w_consume;
    logic               w_invalidate;
    logic [DATA_W-1:0]  w_snap_hi;
    logic               w_snap_valid;
    logic               w_to_done;

    assign w_hit0    = (paddr == TDR0_ADDR);
    assign w_hit1    = (paddr == TDR1_ADDR);
    // Decode/capture only on a live SETUP edge; an aborted SETUP changes nothing.
    assign w_capture = (r_state == SETUP) && psel;

    // Address decode and read-data selection for the capture edge.
    always_comb begin
        w_rd_data    = '0;
        w_err        = 1'b0;
        w_load       = 1'b0;
        w_consume    = 1'b0;
        w_invalidate = 1'b0;
        if (w_capture) begin
            if (pwrite) begin
                w_err        = !(w_hit0 || w_hit1);
                w_invalidate = w_hit0 || w_hit1;
            end else if (w_hit0) begin
                w_rd_data = cnt[DATA_W-1:0];
                w_load    = 1'b1;
            end else if (w_hit1) begin
                w_rd_data = w_snap_valid ? w_snap_hi : cnt[CNT_W-1:DATA_W];
                w_consume = w_snap_valid;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping psel mid-transfer aborts back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (psel && !penable) w_next = SETUP;
            SETUP:   w_next = (WAIT_CYCLES != 0) ? WAIT : DONE;
            WAIT:    if (r_wait_cnt == WAIT_W'(WAIT_CYCLES)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if ((r_state != IDLE) && !psel) begin
            w_next = IDLE;
        end
    end

    assign w_to_done = (w_next == DONE);

    // Wait counter, captured read data and registered APB response.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wait_cnt <= '0;
            r_rd_q     <= '0;
            r_err_q    <= 1'b0;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
        end else begin
            if (w_next == WAIT) begin
                r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + WAIT_W'(1) : WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_capture) begin
                r_rd_q  <= w_rd_data;
                r_err_q <= w_err;
            end
            // With no wait states DONE is entered on the capture edge itself.
            r_pready  <= w_to_done;
            r_pslverr <= w_to_done && (w_capture ? w_err : r_err_q);
            r_prdata  <= (w_to_done && !pwrite) ? (w_capture ? w_rd_data : r_rd_q) : '0;
        end
    end

    timer_snap_reg u_snap (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .i_load       (w_load),
        .i_load_data  (cnt[CNT_W-1:DATA_W]),
        .i_consume    (w_consume),
        .i_invalidate (w_invalidate),
        .o_snap_hi    (w_snap_hi),
        .o_snap_valid (w_snap_valid)
    );

    assign prdata     = r_prdata;
    assign pready     = r_pready;
    assign pslverr    = r_pslverr;
    assign snap_valid = w_snap_valid;

endmodule
